axi_read_responder: RTL and testbench
=====================================

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the read-data path.
REQ-002 Parameter ID_WIDTH, default 4, SHALL set the AXI transaction ID width.
REQ-003 Parameter DEPTH, default 16, SHALL set the read-data FIFO depth in entries and SHALL be a power of two of at least 16.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 cmd_valid  in  1  SHALL indicate a read burst command from the bridge engine.
REQ-007 cmd_ready  out  1  SHALL indicate the block accepts a command this cycle.
REQ-008 cmd_id  in  ID_WIDTH  SHALL carry the ARID of the burst.
REQ-009 cmd_len  in  4  SHALL carry ARLEN, giving beats = cmd_len+1.
REQ-010 fifo_write  in  1  SHALL be the push strobe from the APB master, one pulse per completed APB read.
REQ-011 data_in  in  DATA_WIDTH  SHALL carry PRDATA to be pushed.
REQ-012 err_in  in  1  SHALL carry PSLVERR of the pushed beat.
REQ-013 fifo_full  out  1  SHALL be high when DEPTH entries are held.
REQ-014 rid, rdata, rresp[1:0], rlast, rvalid  out  SHALL form the AXI R channel; rready  in  1  SHALL be the master's acceptance.
REQ-015 done  out  1  SHALL pulse for one cycle when the last beat of a burst is accepted.
REQ-016 overflow  out  1  SHALL be a sticky error flag for a dropped push.

Function
REQ-017 The FIFO SHALL be first-word-fall-through: rdata, rresp reflect the head entry combinationally.
REQ-018 Push SHALL occur when fifo_write=1 and (count<DEPTH, or a pop occurs the same cycle).
REQ-019 A push while full with no simultaneous pop SHALL be dropped and SHALL set overflow to 1 until reset.
REQ-020 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-021 Simultaneous push and pop SHALL leave count unchanged.
REQ-022 The FSM SHALL have states IDLE, STREAM, DONE.
REQ-023 IDLE: cmd_ready=1 and rvalid=0; on cmd_valid, the block SHALL latch cmd_id and cmd_len, clear beat_cnt to 0, and go to STREAM.
REQ-024 STREAM: cmd_ready=0 and rvalid=(count>0); rid = latched id; rlast=(beat_cnt==latched len).
REQ-025 rresp SHALL be 2'b10 (SLVERR) when the head entry's err bit is set, else 2'b00.
REQ-026 A pop SHALL occur only on rvalid&rready; on a pop beat_cnt SHALL increment.
REQ-027 When a pop occurs with rlast=1, the FSM SHALL go to DONE.
REQ-028 DONE: done=1 and rvalid=0 for exactly one cycle, then IDLE.
REQ-029 While rvalid=1 and rready=0, rdata, rresp, rlast and rid SHALL hold stable.
REQ-030 Pushes SHALL be accepted in every state; data pushed before a command SHALL be held until STREAM.
REQ-031 Entries beyond the current burst's length SHALL remain queued for the next burst.
REQ-032 Minimum latency SHALL be one cycle from push into an empty FIFO in STREAM to rvalid=1.

Reset
REQ-033 On rst=1 the block SHALL go to IDLE and clear pointers, count, beat_cnt, latched id/len, and overflow.
REQ-034 During reset: cmd_ready=0, rvalid=0, rlast=0, done=0, fifo_full=0, rresp=0, rid=0.
REQ-035 Reset mid-burst SHALL discard all queued data without emitting further beats.

Verification
REQ-036 Stimulus: cmd id=3, len=3, then 4 pushes 0xA0..0xA3 with rready=1. Required: 4 beats in order, rid=3, rlast only on 0xA3, done one cycle later.
REQ-037 Stimulus: rready toggled 1/0 per cycle during a len=1 burst. Required: rdata, rlast held while stalled; exactly 2 beats.
REQ-038 Stimulus: 16 pushes with no command, then a 17th push. Required: fifo_full=1, 17th dropped, overflow=1; then cmd len=15 drains 16 beats with no loss.
REQ-039 Stimulus: second push with err_in=1 in a len=2 burst. Required: rresp = 00, 10, 00.
REQ-040 Stimulus: rst=1 after the second beat of a len=7 burst. Required: next cycle IDLE, count=0, rvalid=0; a new len=0 burst completes normally.
REQ-041 Stimulus: while full, push and pop occur in the same cycle. Required: push accepted, count stays 16, overflow stays 0.

Source files
------------

// File: rtl/axi_read_responder.sv
// AXI read-data responder: buffers APB read beats in a first-word-fall-through
// FIFO and streams them out on the AXI R channel, one burst per command.
module axi_read_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [3:0]            cmd_len,
    input  logic                  fifo_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  err_in,
    output logic                  fifo_full,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  done,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [3:0]            len_q;
    logic [3:0]            beat_cnt;

    // Each entry stores {err, data}; the err bit selects the beat's response.
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH:0]   head;

    logic                  push;
    logic                  pop;

    // Output decode from registered state; reset forces the control outputs low.
    always_comb begin
        head      = mem[rd_ptr];
        cmd_ready = !rst && (state == IDLE);
        rvalid    = !rst && (state == STREAM) && (count != '0);
        rlast     = !rst && (state == STREAM) && (beat_cnt == len_q);
        rid       = rst ? '0 : id_q;
        rdata     = head[DATA_WIDTH-1:0];
        rresp     = (!rst && head[DATA_WIDTH]) ? 2'b10 : 2'b00;
        done      = !rst && (state == DONE);
        fifo_full = !rst && (count == FULL_CNT);
        pop       = rvalid && rready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push      = fifo_write && !rst && ((count != FULL_CNT) || pop);
    end

    // FIFO storage write; data is not reset, only the pointers that qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {err_in, data_in};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (fifo_write && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Burst sequencer: accept a command, stream len+1 beats, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            id_q     <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        id_q     <= cmd_id;
                        len_q    <= cmd_len;
                        beat_cnt <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (rlast) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed scenarios followed by
// random traffic, all compared against a queue-based burst model.
module tb_axi_read_responder;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_id;
    logic [3:0]    cmd_len;
    logic          fifo_write;
    logic [DW-1:0] data_in;
    logic          err_in;
    logic          fifo_full;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic          done;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued beats, burst bookkeeping, sticky overflow.
    logic [DW:0]   q[$];
    int            phase;      // 0 waiting for command, 1 bursting, 2 done pulse
    logic [IW-1:0] m_id;
    int            m_left;     // beats still owed to the current burst
    logic          m_ovf;
    logic          rst_cur;

    always #5 clk = ~clk;

    axi_read_responder #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .fifo_write(fifo_write), .data_in(data_in), .err_in(err_in), .fifo_full(fifo_full),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .done(done), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_rv;
        exp_rv = !rst_cur && phase == 1 && q.size() > 0;
        chk("cmd_ready", 64'(cmd_ready), 64'(!rst_cur && phase == 0));
        chk("rvalid",    64'(rvalid),    64'(exp_rv));
        chk("done",      64'(done),      64'(!rst_cur && phase == 2));
        chk("fifo_full", 64'(fifo_full), 64'(!rst_cur && q.size() == DEPTH));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        if (exp_rv) begin
            chk("rdata", 64'(rdata), 64'(q[0][DW-1:0]));
            chk("rresp", 64'(rresp), q[0][DW] ? 64'd2 : 64'd0);
            chk("rlast", 64'(rlast), 64'(m_left == 1));
            chk("rid",   64'(rid),   64'(m_id));
        end
        if (rst_cur) begin
            chk("rst_rid",   64'(rid),   64'd0);
            chk("rst_rresp", 64'(rresp), 64'd0);
            chk("rst_rlast", 64'(rlast), 64'd0);
        end
    endtask

    // One clock cycle: check current outputs, drive new inputs, advance the model.
    task automatic cyc(input logic cv, input logic [IW-1:0] cid, input logic [3:0] clen,
                       input logic fw, input logic [DW-1:0] din, input logic er,
                       input logic rr, input logic r);
        logic pop;
        @(negedge clk);
        check_outputs();
        cmd_valid = cv; cmd_id = cid; cmd_len = clen;
        fifo_write = fw; data_in = din; err_in = er;
        rready = rr; rst = r;
        if (r) begin
            q.delete();
            phase = 0; m_id = '0; m_left = 0; m_ovf = 1'b0;
        end else begin
            pop = (phase == 1) && (q.size() > 0) && rr;
            if (pop) begin
                void'(q.pop_front());
                m_left--;
            end
            if (fw) begin
                if (q.size() < DEPTH) q.push_back({er, din});
                else m_ovf = 1'b1;
            end
            if (phase == 2) phase = 0;
            else if (phase == 1 && pop && m_left == 0) phase = 2;
            else if (phase == 0 && cv) begin
                phase = 1; m_id = cid; m_left = int'(clen) + 1;
            end
        end
        rst_cur = r;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, 0, rr, 0);
    endtask

    task automatic cmd(input logic [IW-1:0] cid, input logic [3:0] clen);
        cyc(1, cid, clen, 0, '0, 0, 0, 0);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic e, input logic rr);
        cyc(0, '0, '0, 1, d, e, rr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_id = '0; cmd_len = '0;
        fifo_write = 0; data_in = '0; err_in = 0; rready = 0;
        q.delete(); phase = 0; m_id = '0; m_left = 0; m_ovf = 0; rst_cur = 1'b1;

        // Reset held for a few cycles.
        for (int i = 0; i < 3; i++) cyc(0, '0, '0, 0, '0, 0, 0, 1);
        idle(2, 0);

        // Basic 4-beat burst, id 3.
        cmd(4'd3, 4'd3);
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 0, 1);
        idle(4, 1);

        // Len=1 burst with rready toggling each cycle.
        cmd(4'd5, 4'd1);
        push(32'hC0, 0, 0);
        push(32'hC1, 0, 1);
        for (int i = 0; i < 8; i++) idle(1, logic'(i % 2));
        idle(2, 1);

        // Fill with no command, overflow on the 17th push, then drain 16.
        for (int i = 0; i < 17; i++) push(32'h100 + 32'(i), 0, 0);
        cmd(4'd7, 4'd15);
        idle(20, 1);

        // Error on the middle beat of a 3-beat burst.
        cmd(4'd2, 4'd2);
        push(32'hB0, 0, 1);
        push(32'hB1, 1, 1);
        push(32'hB2, 0, 1);
        idle(4, 1);

        // Reset after two beats of a len=7 burst, then a clean len=0 burst.
        cmd(4'd9, 4'd7);
        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i), 0, 0);
        idle(2, 1);
        cyc(0, '0, '0, 0, '0, 0, 1, 1);
        idle(3, 1);
        cmd(4'd4, 4'd0);
        push(32'hE0, 0, 1);
        idle(4, 1);

        // Push and pop together while full: count holds, no overflow.
        for (int i = 0; i < 16; i++) push(32'h200 + 32'(i), 0, 0);
        cmd(4'd1, 4'd15);
        push(32'h2FF, 0, 1);
        push(32'h2FE, 1, 0);
        idle(20, 1);
        cyc(0, '0, '0, 0, '0, 0, 0, 1);
        idle(2, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 4) == 0, IW'($urandom), 4'($urandom % 16),
                ($urandom % 2) == 0, $urandom, ($urandom % 5) == 0,
                ($urandom % 4) != 0, ($urandom % 300) == 0);
        end
        idle(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
